timer_unit: RTL and testbench

//  Memory-mapped bus responder for the DIV/TIMA/TMA/TAC timer registers at FF04-FF07.

---
 rtl/timer_unit_pkg.sv | 45 ++++
 rtl/timer_unit_if.sv | 23 ++
 rtl/timer_unit_divider.sv | 39 +++
 rtl/timer_unit.sv | 105 ++++++++++
 tb/tb_timer_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_unit_pkg.sv
// Shared constants and types for the DIV/TIMA/TMA/TAC timer block.
package timer_unit_pkg;

    localparam logic [15:0] TIMER_DIV_ADDR  = 16'hFF04;
    localparam logic [15:0] TIMER_TIMA_ADDR = 16'hFF05;
    localparam logic [15:0] TIMER_TMA_ADDR  = 16'hFF06;
    localparam logic [15:0] TIMER_TAC_ADDR  = 16'hFF07;

    // TAC[7:3] are not stored and always read back as ones
    localparam logic [4:0] TAC_UNUSED_BITS = 5'b11111;

    typedef enum logic [1:0] {
        TAC_4096   = 2'b00,
        TAC_262144 = 2'b01,
        TAC_65536  = 2'b10,
        TAC_16384  = 2'b11
    } tac_clk_t;

    typedef struct packed {
        logic     en;
        tac_clk_t clk_sel;
    } tac_t;

    // Register offset within the four-byte window
    typedef enum logic [1:0] {
        SEL_DIV  = 2'b00,
        SEL_TIMA = 2'b01,
        SEL_TMA  = 2'b10,
        SEL_TAC  = 2'b11
    } reg_sel_t;

    // Divider bit whose falling edge clocks TIMA for each TAC rate
    function automatic logic [3:0] tac_bitsel(input tac_clk_t clk_sel);
        logic [3:0] bit_idx;
        case (clk_sel)
            TAC_4096:   bit_idx = 4'd9;
            TAC_262144: bit_idx = 4'd3;
            TAC_65536:  bit_idx = 4'd5;
            TAC_16384:  bit_idx = 4'd7;
            default:    bit_idx = 4'd9;
        endcase
        return bit_idx;
    endfunction

endpackage

// File: rtl/timer_unit_if.sv
// CPU-side bus signals seen by the timer block (the tri-state data bus stays a plain port).
interface timer_unit_if;

    logic [15:0] address;
    logic        RE;
    logic        WE;
    logic        timer_irq;

    modport master (
        output address,
        output RE,
        output WE,
        input  timer_irq
    );

    modport slave (
        input  address,
        input  RE,
        input  WE,
        output timer_irq
    );

endinterface

// File: rtl/timer_unit_divider.sv
// Free-running divider with synchronous clear and falling-edge tick generation for TIMA.
module timer_unit_divider
    import timer_unit_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,   // DIV write this cycle
    input  tac_t       tac,     // TAC value after this cycle's write
    output logic [7:0] div_hi,
    output logic       tick
);

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tsig_q, tsig_d;

    // Next divider value and the gated tap it produces; both see this cycle's writes
    always_comb begin
        div_d  = clear ? '0 : div_q + DIV_WIDTH'(1);
        tsig_d = tac.en & div_d[tac_bitsel(tac.clk_sel)];
    end

    // A 1->0 transition of the tap ticks TIMA, including drops caused by DIV/TAC writes
    assign tick   = tsig_q & ~tsig_d;
    assign div_hi = div_q[15:8];

    // Divider and previous-tap state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tsig_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tsig_q <= tsig_d;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Timer register file at BASE_ADDR..BASE_ADDR+3: bus decode, tri-state read driver,
// TIMA counting with delayed TMA reload and a one-cycle interrupt pulse.
module timer_unit
    import timer_unit_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = TIMER_DIV_ADDR,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    timer_unit_if.slave  bus,
    inout  wire  [7:0]   databus
);

    logic       hit;
    logic       wr_en;
    logic       rd_en;
    reg_sel_t   sel;
    logic [7:0] wdata;
    logic [7:0] rd_data;
    logic [7:0] div_hi;
    logic       div_clear;
    logic       tick;

    logic [7:0] tima_q, tima_d;
    logic [7:0] tma_q, tma_d;
    tac_t       tac_q, tac_d;
    logic       reload_pend_q, reload_pend_d;

    assign hit   = (bus.address[15:2] == BASE_ADDR[15:2]);
    assign sel   = reg_sel_t'(bus.address[1:0]);
    assign wdata = databus;
    assign wr_en = bus.WE & hit;
    // Reset releases the bus even while a read is being presented
    assign rd_en = bus.RE & hit & ~bus.WE & ~rst;

    assign div_clear = wr_en & (sel == SEL_DIV);

    timer_unit_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_divider (
        .clk    (clk),
        .rst    (rst),
        .clear  (div_clear),
        .tac    (tac_d),
        .div_hi (div_hi),
        .tick   (tick)
    );

    // Register next state: reload beats a TIMA write, which beats a tick
    always_comb begin
        tac_d         = tac_q;
        tma_d         = tma_q;
        tima_d        = tima_q;
        reload_pend_d = 1'b0;

        if (wr_en && sel == SEL_TAC) begin
            tac_d = tac_t'(wdata[2:0]);
        end
        if (wr_en && sel == SEL_TMA) begin
            tma_d = wdata;
        end

        if (reload_pend_q) begin
            // TIMA held 00 for one cycle; a same-cycle TMA write is what gets loaded
            tima_d = tma_d;
        end else if (wr_en && sel == SEL_TIMA) begin
            // Also swallows an overflow in this cycle, so no reload and no irq follow
            tima_d = wdata;
        end else if (tick) begin
            tima_d        = tima_q + 8'd1;
            reload_pend_d = (tima_q == 8'hFF);
        end
    end

    // Read data mux for the combinational read path
    always_comb begin
        rd_data = '0;
        unique case (sel)
            SEL_DIV:  rd_data = div_hi;
            SEL_TIMA: rd_data = tima_q;
            SEL_TMA:  rd_data = tma_q;
            SEL_TAC:  rd_data = {TAC_UNUSED_BITS, tac_q};
        endcase
    end

    assign databus       = rd_en ? rd_data : 8'bz;
    assign bus.timer_irq = reload_pend_q;

    // Timer register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tima_q        <= '0;
            tma_q         <= '0;
            tac_q         <= '0;
            reload_pend_q <= 1'b0;
        end else begin
            tima_q        <= tima_d;
            tma_q         <= tma_d;
            tac_q         <= tac_d;
            reload_pend_q <= reload_pend_d;
        end
    end

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: each bus operation queues its expected response and a
// negedge monitor compares databus and timer_irq while the operation is presented.
module tb_timer_unit;
    import timer_unit_pkg::*;

    typedef struct packed {
        logic       chk_data;
        logic       rel;      // bus must be released
        logic [7:0] data;
        logic       irq;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        tb_drv;
    logic [7:0]  tb_wdata;
    logic        op_active;
    wire  [7:0]  databus;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    timer_unit_if bus ();

    assign databus = tb_drv ? tb_wdata : 8'bz;

    timer_unit dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per presented operation
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (op_active) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: operation at %0t has no expectation", $time);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (e.chk_data) begin
                    checks++;
                    if (e.rel) begin
                        // An undriven bus may resolve to 00 in a two-state simulator
                        if (!(databus === 8'hzz || databus === 8'h00)) begin
                            errors++;
                            $display("FAIL %s: databus got %h, required released (z)", t, databus);
                        end
                    end else if (databus !== e.data) begin
                        errors++;
                        $display("FAIL %s: databus got %h, required %h", t, databus, e.data);
                    end
                end
                checks++;
                if (bus.timer_irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s_irq: timer_irq got %b, required %b", t, bus.timer_irq, e.irq);
                end
            end
        end
    end

    task automatic push_exp(input logic cd, input logic rl, input logic [7:0] d, input logic irq,
                            input string tag);
        exp_t e;
        e.chk_data = cd;
        e.rel      = rl;
        e.data     = d;
        e.irq      = irq;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // All operations start 1 time unit after a posedge and consume exactly one posedge
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic irq, input string tag);
        push_exp(1'b0, 1'b0, 8'h00, irq, tag);
        bus.address = a;
        bus.WE      = 1'b1;
        bus.RE      = 1'b0;
        tb_wdata    = d;
        tb_drv      = 1'b1;
        op_active   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE    = 1'b0;
        tb_drv    = 1'b0;
        op_active = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic irq, input string tag);
        push_exp(1'b1, 1'b0, d, irq, tag);
        bus.address = a;
        bus.RE      = 1'b1;
        bus.WE      = 1'b0;
        op_active   = 1'b1;
        @(posedge clk);
        #1;
        bus.RE    = 1'b0;
        op_active = 1'b0;
    endtask

    task automatic rd_rel(input logic [15:0] a, input string tag);
        push_exp(1'b1, 1'b1, 8'h00, 1'b0, tag);
        bus.address = a;
        bus.RE      = 1'b1;
        bus.WE      = 1'b0;
        op_active   = 1'b1;
        @(posedge clk);
        #1;
        bus.RE    = 1'b0;
        op_active = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clear DIV with counting off, enable TAC=05, then load TIMA; div = 2 afterwards
    task automatic setup_run(input logic [7:0] tima_init);
        wr(TIMER_TAC_ADDR, 8'h00, 1'b0, "setup_tac_off");
        wr(TIMER_DIV_ADDR, 8'hA5, 1'b0, "setup_div_clr");
        wr(TIMER_TAC_ADDR, 8'h05, 1'b0, "setup_tac_05");
        wr(TIMER_TIMA_ADDR, tima_init, 1'b0, "setup_tima");
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        tb_drv      = 1'b0;
        tb_wdata    = 8'h00;
        op_active   = 1'b0;
        bus.address = 16'h0000;
        bus.RE      = 1'b0;
        bus.WE      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset values and decode boundaries
        rd(TIMER_DIV_ADDR,  8'h00, 1'b0, "rst_div");
        rd(TIMER_TIMA_ADDR, 8'h00, 1'b0, "rst_tima");
        rd(TIMER_TMA_ADDR,  8'h00, 1'b0, "rst_tma");
        rd(TIMER_TAC_ADDR,  8'hF8, 1'b0, "rst_tac");
        rd_rel(16'hFF03, "miss_ff03");
        rd_rel(16'hFF08, "miss_ff08");

        // 2: FE -> FF at div 16, 00 with irq at div 32, TMA reload at div 33
        wr(TIMER_TMA_ADDR, 8'hF0, 1'b0, "t2_tma");
        setup_run(8'hFE);
        for (int n = 2; n <= 39; n++) begin
            rd(TIMER_TIMA_ADDR,
               (n < 16) ? 8'hFE : (n < 32) ? 8'hFF : (n == 32) ? 8'h00 : 8'hF0,
               (n == 32), "t2_tima");
        end

        // 3: DIV write while div[3]=1 ticks TIMA; with TAC disabled it does not
        wr(TIMER_TAC_ADDR, 8'h00, 1'b0, "t3_tac_off");
        wr(TIMER_DIV_ADDR, 8'h00, 1'b0, "t3_div_clr");
        wr(TIMER_TAC_ADDR, 8'h05, 1'b0, "t3_tac_05");
        wr(TIMER_TIMA_ADDR, 8'h10, 1'b0, "t3_tima");
        for (int i = 0; i < 7; i++) rd(TIMER_TIMA_ADDR, 8'h10, 1'b0, "t3_tima_hold");
        wr(TIMER_DIV_ADDR, 8'h00, 1'b0, "t3_div_tick");
        rd(TIMER_DIV_ADDR,  8'h00, 1'b0, "t3_div_zero");
        rd(TIMER_TIMA_ADDR, 8'h11, 1'b0, "t3_tima_inc");
        wr(TIMER_TAC_ADDR, 8'h01, 1'b0, "t3_tac_01");
        for (int i = 0; i < 7; i++) rd(TIMER_TIMA_ADDR, 8'h11, 1'b0, "t3_tima_hold2");
        wr(TIMER_DIV_ADDR, 8'h00, 1'b0, "t3_div_noclk");
        rd(TIMER_TIMA_ADDR, 8'h11, 1'b0, "t3_tima_noinc");
        rd(TIMER_DIV_ADDR,  8'h00, 1'b0, "t3_div_zero2");

        // 4a: TIMA write in the overflow cycle cancels reload and irq
        setup_run(8'hFE);
        for (int n = 2; n <= 30; n++) rd(TIMER_TIMA_ADDR, (n < 16) ? 8'hFE : 8'hFF, 1'b0, "t4a_tima");
        wr(TIMER_TIMA_ADDR, 8'h42, 1'b0, "t4a_wr_ovf");
        rd(TIMER_TIMA_ADDR, 8'h42, 1'b0, "t4a_no_reload");
        rd(TIMER_TIMA_ADDR, 8'h42, 1'b0, "t4a_tima_hold");

        // 4b: TIMA write in the reload cycle is ignored, TMA loads, irq fires
        setup_run(8'hFE);
        for (int n = 2; n <= 31; n++) rd(TIMER_TIMA_ADDR, (n < 16) ? 8'hFE : 8'hFF, 1'b0, "t4b_tima");
        wr(TIMER_TIMA_ADDR, 8'h42, 1'b1, "t4b_wr_reload");
        rd(TIMER_TIMA_ADDR, 8'hF0, 1'b0, "t4b_tima_tma");
        rd(TIMER_TMA_ADDR,  8'hF0, 1'b0, "t4b_tma");

        // 4c: TMA write in the reload cycle is the value loaded
        setup_run(8'hFE);
        for (int n = 2; n <= 31; n++) rd(TIMER_TIMA_ADDR, (n < 16) ? 8'hFE : 8'hFF, 1'b0, "t4c_tima");
        wr(TIMER_TMA_ADDR, 8'h33, 1'b1, "t4c_wr_tma");
        rd(TIMER_TIMA_ADDR, 8'h33, 1'b0, "t4c_tima_new_tma");
        rd(TIMER_TMA_ADDR,  8'h33, 1'b0, "t4c_tma");

        // 5: TAC readback, DIV high byte, slowest TIMA rate
        wr(TIMER_TAC_ADDR, 8'hFD, 1'b0, "t5_tac_fd");
        rd(TIMER_TAC_ADDR, 8'hFD, 1'b0, "t5_tac_read");
        wr(TIMER_TAC_ADDR, 8'h00, 1'b0, "t5_tac_off");
        wr(TIMER_DIV_ADDR, 8'h00, 1'b0, "t5_div_clr");
        wr(TIMER_TAC_ADDR, 8'h04, 1'b0, "t5_tac_04");
        wr(TIMER_TIMA_ADDR, 8'h00, 1'b0, "t5_tima");
        wr(TIMER_DIV_ADDR, 8'h00, 1'b0, "t5_div_clr2");
        idle(255);
        rd(TIMER_DIV_ADDR, 8'h00, 1'b0, "t5_div_255");
        rd(TIMER_DIV_ADDR, 8'h01, 1'b0, "t5_div_256");
        idle(766);
        rd(TIMER_TIMA_ADDR, 8'h00, 1'b0, "t5_tima_1023");
        rd(TIMER_TIMA_ADDR, 8'h01, 1'b0, "t5_tima_1024");

        // 6: reset while a reload is pending, then resume
        wr(TIMER_TMA_ADDR, 8'h7F, 1'b0, "t6_tma");
        setup_run(8'hFF);
        for (int n = 2; n <= 15; n++) rd(TIMER_TIMA_ADDR, 8'hFF, 1'b0, "t6_tima");
        rst = 1'b1;
        rd_rel(TIMER_TAC_ADDR,  "t6_rst_tac_rel");
        rd_rel(TIMER_TIMA_ADDR, "t6_rst_tima_rel");
        rst = 1'b0;
        rd(TIMER_DIV_ADDR,  8'h00, 1'b0, "t6_div");
        rd(TIMER_TIMA_ADDR, 8'h00, 1'b0, "t6_tima_clr");
        rd(TIMER_TMA_ADDR,  8'h00, 1'b0, "t6_tma_clr");
        rd(TIMER_TAC_ADDR,  8'hF8, 1'b0, "t6_tac_clr");
        wr(TIMER_TAC_ADDR, 8'h05, 1'b0, "t6_tac_05");
        for (int m = 5; m <= 17; m++) rd(TIMER_TIMA_ADDR, (m < 16) ? 8'h00 : 8'h01, 1'b0, "t6_resume");

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
